display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_if.sv | 23 ++
 rtl/display_scan.sv | 153 +++++++++++++++
 tb/tb_display_scan.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Bundle of load/pattern inputs and multiplexed display outputs for display_scan.
// master drives loads and patterns; slave is the scanner.
interface display_scan_if;
    logic       load;
    logic [0:6] min_segs;
    logic [0:6] sec_tens_segs;
    logic [0:6] sec_ones_segs;
    logic [0:6] seg;
    logic       dp;
    logic [2:0] an;
    logic       load_ack;
    logic       frame_start;

    modport master (
        output load, min_segs, sec_tens_segs, sec_ones_segs,
        input  seg, dp, an, load_ack, frame_start
    );

    modport slave (
        input  load, min_segs, sec_tens_segs, sec_ones_segs,
        output seg, dp, an, load_ack, frame_start
    );
endinterface

// File: rtl/display_scan.sv
// Three-digit multiplexed 7-segment scanner (sec ones, sec tens, minutes) with
// blanking guard per slot and frame-synchronous double-buffered pattern loads.
module display_scan #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.slave bus
);

    localparam int unsigned    CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);
    localparam logic [0:6]      SegOff   = 7'b1111111;

    typedef enum logic [1:0] {DigOnes = 2'd0, DigTens = 2'd1, DigMin = 2'd2} digit_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    digit_e          dig_q, dig_d;
    logic            started_q, started_d;
    logic [0:6]      disp_ones_q, disp_ones_d, disp_tens_q, disp_tens_d;
    logic [0:6]      disp_min_q, disp_min_d;
    logic [0:6]      pend_ones_q, pend_ones_d, pend_tens_q, pend_tens_d;
    logic [0:6]      pend_min_q, pend_min_d;
    logic            pend_valid_q, pend_valid_d;
    logic [0:6]      seg_q, seg_d;
    logic [2:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic            ack_q, ack_d;
    logic            fs_q, fs_d;
    logic            frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            dig_q        <= DigOnes;
            started_q    <= 1'b0;
            disp_ones_q  <= SegOff;
            disp_tens_q  <= SegOff;
            disp_min_q   <= SegOff;
            pend_ones_q  <= SegOff;
            pend_tens_q  <= SegOff;
            pend_min_q   <= SegOff;
            pend_valid_q <= 1'b0;
            seg_q        <= SegOff;
            an_q         <= 3'b111;
            dp_q         <= 1'b1;
            ack_q        <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            started_q    <= started_d;
            disp_ones_q  <= disp_ones_d;
            disp_tens_q  <= disp_tens_d;
            disp_min_q   <= disp_min_d;
            pend_ones_q  <= pend_ones_d;
            pend_tens_q  <= pend_tens_d;
            pend_min_q   <= pend_min_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            ack_q        <= ack_d;
            fs_q         <= fs_d;
        end
    end

    // Counter holds at 0/ones for the first edge after reset so that cycle is frame start.
    always_comb begin
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        started_d = 1'b1;
        if (started_q) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                unique case (dig_q)
                    DigOnes: dig_d = DigTens;
                    DigTens: dig_d = DigMin;
                    default: dig_d = DigOnes;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign frame = (cnt_d == '0) && (dig_d == DigOnes);

    always_comb begin
        disp_ones_d  = disp_ones_q;
        disp_tens_d  = disp_tens_q;
        disp_min_d   = disp_min_q;
        pend_ones_d  = pend_ones_q;
        pend_tens_d  = pend_tens_q;
        pend_min_d   = pend_min_q;
        pend_valid_d = pend_valid_q;
        ack_d        = 1'b0;
        if (frame) begin
            pend_valid_d = 1'b0;
            if (bus.load) begin
                disp_ones_d = bus.sec_ones_segs;
                disp_tens_d = bus.sec_tens_segs;
                disp_min_d  = bus.min_segs;
                ack_d       = 1'b1;
            end else if (pend_valid_q) begin
                disp_ones_d = pend_ones_q;
                disp_tens_d = pend_tens_q;
                disp_min_d  = pend_min_q;
                ack_d       = 1'b1;
            end
        end else if (bus.load) begin
            pend_ones_d  = bus.sec_ones_segs;
            pend_tens_d  = bus.sec_tens_segs;
            pend_min_d   = bus.min_segs;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they match the counter of their cycle.
    always_comb begin
        an_d  = 3'b111;
        seg_d = SegOff;
        dp_d  = 1'b1;
        fs_d  = frame;
        if (cnt_d >= BlankEnd) begin
            unique case (dig_d)
                DigOnes: begin
                    an_d  = 3'b110;
                    seg_d = disp_ones_d;
                end
                DigTens: begin
                    an_d  = 3'b101;
                    seg_d = disp_tens_d;
                end
                DigMin: begin
                    an_d  = 3'b011;
                    seg_d = disp_min_d;
                    dp_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.dp          = dp_q;
    assign bus.load_ack    = ack_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios plus random load/reset against a
// cycle-indexed reference model of the scan schedule.
module tb_display_scan;

    localparam int unsigned Div   = 8;
    localparam int unsigned Blank = 2;
    localparam int unsigned Frame = 3 * Div;
    localparam int          LogN  = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_if ifc ();

    display_scan #(
        .REFRESH_DIV (Div),
        .BLANK_CYCLES(Blank)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: index 0 = sec ones, 1 = sec tens, 2 = minutes.
    bit         m_started;
    int         m_n;
    logic [0:6] m_disp[3];
    logic [0:6] m_pend[3];
    bit         m_pv;
    logic [2:0] e_an;
    logic [0:6] e_seg;
    logic       e_dp, e_ack, e_fs;

    logic [0:6] seg_log[LogN];
    logic [2:0] an_log[LogN];
    logic       dp_log[LogN];
    logic       ack_log[LogN];
    logic       fs_log[LogN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input logic [0:6] mi,
                              input logic [0:6] ti, input logic [0:6] oi);
        int pos, slot, c;
        if (r) begin
            m_started = 0;
            m_n = 0;
            m_pv = 0;
            for (int i = 0; i < 3; i++) begin
                m_disp[i] = 7'b1111111;
                m_pend[i] = 7'b1111111;
            end
            e_an = 3'b111; e_seg = 7'b1111111; e_dp = 1'b1; e_ack = 1'b0; e_fs = 1'b0;
        end else begin
            m_n = m_started ? m_n + 1 : 0;
            m_started = 1;
            pos  = m_n % Frame;
            slot = pos / Div;
            c    = pos % Div;
            e_fs = (pos == 0);
            e_ack = 1'b0;
            if (pos == 0) begin
                if (ld) begin
                    m_disp[0] = oi; m_disp[1] = ti; m_disp[2] = mi;
                    e_ack = 1'b1;
                end else if (m_pv) begin
                    m_disp = m_pend;
                    e_ack = 1'b1;
                end
                m_pv = 0;
            end else if (ld) begin
                m_pend[0] = oi; m_pend[1] = ti; m_pend[2] = mi;
                m_pv = 1;
            end
            if (c < Blank) begin
                e_an = 3'b111; e_seg = 7'b1111111; e_dp = 1'b1;
            end else begin
                e_an  = 3'b111 ^ (3'b001 << slot);
                e_seg = m_disp[slot];
                e_dp  = (slot != 2);
            end
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [20:0] pat, input int k);
        reset = r;
        ifc.load = ld;
        {ifc.min_segs, ifc.sec_tens_segs, ifc.sec_ones_segs} = pat;
        @(posedge clk);
        #1;
        model_step(r, ld, pat[20:14], pat[13:7], pat[6:0]);
        chk("an", 32'(ifc.an), 32'(e_an));
        chk("seg", 32'(ifc.seg), 32'(e_seg));
        chk("dp", 32'(ifc.dp), 32'(e_dp));
        chk("load_ack", 32'(ifc.load_ack), 32'(e_ack));
        chk("frame_start", 32'(ifc.frame_start), 32'(e_fs));
        if (k >= 0 && k < LogN) begin
            seg_log[k] = ifc.seg; an_log[k] = ifc.an; dp_log[k] = ifc.dp;
            ack_log[k] = ifc.load_ack; fs_log[k] = ifc.frame_start;
        end
    endtask

    task automatic run(input int len, input int l1, input logic [20:0] p1,
                       input int l2, input logic [20:0] p2, input int rst_at);
        logic [20:0] pat;
        bit ld;
        step(1'b1, 1'b0, 21'($urandom), -1);
        step(1'b1, 1'b1, 21'($urandom), -1);
        for (int k = 0; k < len; k++) begin
            ld  = (k == l1) || (k == l2);
            pat = (k == l2) ? p2 : (k == l1) ? p1 : 21'($urandom);
            step(k == rst_at, ld, pat, k);
        end
    endtask

    function automatic int acks(input int len);
        int s = 0;
        for (int k = 0; k < len; k++) s += int'(ack_log[k]);
        return s;
    endfunction

    // Anode exclusivity and blank-segment invariant on every cycle.
    always @(negedge clk) begin
        if (!$isunknown(ifc.an)) begin
            n_cmp++;
            assert ($countones(~ifc.an) <= 1)
            else begin
                n_err++;
                $error("FAIL an_onehot observed=%b expected=at most one low", ifc.an);
            end
            n_cmp++;
            assert (ifc.an != 3'b111 || ifc.seg == 7'b1111111)
            else begin
                n_err++;
                $error("FAIL seg_blank observed=%b expected=1111111", ifc.seg);
            end
        end
    end

    logic [20:0] pa, pb;

    initial begin
        pa = {7'b0010010, 7'b0100100, 7'b1001111};
        pb = {7'b0000001, 7'b1001100, 7'b0000110};
        ifc.load = 1'b0;
        ifc.min_segs = '0; ifc.sec_tens_segs = '0; ifc.sec_ones_segs = '0;

        // No load: schedule only.
        run(49, -1, pa, -1, pa, -1);
        chk("fs_c0", 32'(fs_log[0]), 1);
        chk("fs_c24", 32'(fs_log[24]), 1);
        chk("fs_c48", 32'(fs_log[48]), 1);
        chk("an_c1", 32'(an_log[1]), 32'b111);
        chk("an_c2", 32'(an_log[2]), 32'b110);
        chk("an_c10", 32'(an_log[10]), 32'b101);
        chk("an_c18", 32'(an_log[18]), 32'b011);
        chk("seg_c20", 32'(seg_log[20]), 32'h7f);

        // Single load mid-frame.
        run(48, 5, pa, -1, pa, -1);
        chk("ack_c23", 32'(ack_log[23]), 0);
        chk("ack_c24", 32'(ack_log[24]), 1);
        chk("seg_c12", 32'(seg_log[12]), 32'h7f);
        chk("seg_c26", 32'(seg_log[26]), 32'(7'b1001111));
        chk("dp_c41", 32'(dp_log[41]), 1);
        chk("dp_c42", 32'(dp_log[42]), 0);
        chk("seg_c42", 32'(seg_log[42]), 32'(7'b0010010));

        // Two loads before transfer: last wins.
        run(48, 5, pa, 12, pb, -1);
        chk("acks_ab", acks(48), 1);
        chk("seg_b_ones", 32'(seg_log[26]), 32'(pb[6:0]));
        chk("seg_b_tens", 32'(seg_log[34]), 32'(pb[13:7]));

        // Load exactly at frame start.
        run(32, 24, pb, -1, pb, -1);
        chk("ack_fs_c24", 32'(ack_log[24]), 1);
        chk("acks_fs", acks(32), 1);
        chk("seg_fs_c26", 32'(seg_log[26]), 32'(pb[6:0]));

        // Reset between load and transfer.
        run(62, 9, pa, -1, pa, 13);
        chk("an_rst", 32'(an_log[13]), 32'b111);
        chk("seg_rst", 32'(seg_log[13]), 32'h7f);
        chk("fs_after_rst", 32'(fs_log[14]), 1);
        chk("acks_rst", acks(62), 0);
        chk("seg_after_rst", 32'(seg_log[40]), 32'h7f);

        // Random loads, patterns and resets.
        step(1'b1, 1'b0, 21'($urandom), -1);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) == 0, $urandom_range(9) == 0, 21'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
